// File: rtl/floatingpoint.sv
// Shared single-precision definitions: float layout, classification helpers,
// and the types used by the float-to-int sequencer.
package floatingpoint;

  localparam int FP_EXPONENT_BITS = 8;
  localparam int FP_FRACTION_BITS = 23;
  localparam int FP_BIAS          = 127;

  typedef struct packed {
    logic                        sign;
    logic [FP_EXPONENT_BITS-1:0] exponent;
    logic [FP_FRACTION_BITS-1:0] fraction;
  } float_t;

  // Sequencer states for the float-to-int conversion.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    NEGATE   = 3'd3,
    DONE     = 3'd4
  } f2i_state_t;

  // Result flags, nan in the MSB.
  typedef struct packed {
    logic nan;
    logic inf;
    logic overflow;
    logic zero;
    logic inexact;
  } f2i_flags_t;

  function automatic logic iszero(input float_t f);
    return (f.exponent == {FP_EXPONENT_BITS{1'b0}}) &&
           (f.fraction == {FP_FRACTION_BITS{1'b0}});
  endfunction

  function automatic logic isnan(input float_t f);
    return (f.exponent == {FP_EXPONENT_BITS{1'b1}}) &&
           (f.fraction != {FP_FRACTION_BITS{1'b0}});
  endfunction

  function automatic logic isinfinity(input float_t f);
    return (f.exponent == {FP_EXPONENT_BITS{1'b1}}) &&
           (f.fraction == {FP_FRACTION_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of an IEEE single operand.
module fp_classify
  import floatingpoint::*;
(
  input  float_t f,
  output logic   is_nan,
  output logic   is_inf,
  output logic   is_zero,
  output logic   is_denorm
);

  // Special-value decode built on the package helpers.
  always_comb begin
    is_nan    = isnan(f);
    is_inf    = isinfinity(f);
    is_zero   = iszero(f);
    is_denorm = (f.exponent == {FP_EXPONENT_BITS{1'b0}}) && !iszero(f);
  end

endmodule

// File: rtl/float_to_int_seq.sv
// Multi-cycle IEEE single to signed 32-bit integer converter. Magnitude is
// aligned one bit per cycle; rounding truncates toward zero.
module float_to_int_seq
  import floatingpoint::*;
#(
  parameter int EXPONENT_BITS = FP_EXPONENT_BITS,
  parameter int FRACTION_BITS = FP_FRACTION_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic [4:0]  out_flags
);

  f2i_state_t state_r, state_next;
  float_t     op_r, op_next;
  logic [31:0] mag_r, mag_next;
  logic [4:0]  cnt_r, cnt_next;
  logic        left_r, left_next;
  logic        sticky_r, sticky_next;
  logic [31:0] out_int_r, out_int_next;
  f2i_flags_t  out_flags_r, out_flags_next;
  logic        out_valid_r, out_valid_next;

  logic is_nan_s, is_inf_s, is_zero_s, is_denorm_s;
  logic signed [EXPONENT_BITS+1:0] e_s;
  logic [31:0] sat_s;

  fp_classify u_classify (
    .f         (op_r),
    .is_nan    (is_nan_s),
    .is_inf    (is_inf_s),
    .is_zero   (is_zero_s),
    .is_denorm (is_denorm_s)
  );

  // Unbiased exponent and the signed saturation value for the held operand.
  always_comb begin
    e_s   = $signed({2'b00, op_r.exponent}) - $signed(10'(FP_BIAS));
    sat_s = op_r.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Next-state and datapath update; in_ready/out_valid never depend on out_ready combinationally.
  always_comb begin
    state_next     = state_r;
    op_next        = op_r;
    mag_next       = mag_r;
    cnt_next       = cnt_r;
    left_next      = left_r;
    sticky_next    = sticky_r;
    out_int_next   = out_int_r;
    out_flags_next = out_flags_r;
    out_valid_next = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_next    = float_t'(in_bits);
          state_next = CLASSIFY;
        end else begin
          state_next = IDLE;
        end
      end
      CLASSIFY: begin
        if (is_nan_s) begin
          out_int_next   = 32'h7FFF_FFFF;
          out_flags_next = f2i_flags_t'(5'b10000);
          state_next     = DONE;
        end else if (is_inf_s) begin
          out_int_next   = sat_s;
          out_flags_next = f2i_flags_t'(5'b01000);
          state_next     = DONE;
        end else if (is_zero_s) begin
          out_int_next   = 32'h0000_0000;
          out_flags_next = f2i_flags_t'(5'b00010);
          state_next     = DONE;
        end else if (is_denorm_s || (e_s < 10'sd0)) begin
          out_int_next   = 32'h0000_0000;
          out_flags_next = f2i_flags_t'(5'b00011);
          state_next     = DONE;
        end else if ((e_s > 10'sd31) ||
                     ((e_s == 10'sd31) && !(op_r.sign && (op_r.fraction == {FRACTION_BITS{1'b0}})))) begin
          out_int_next   = sat_s;
          out_flags_next = f2i_flags_t'(5'b00100);
          state_next     = DONE;
        end else begin
          // Exact -2^31 takes this path too and is left-shifted by 8.
          mag_next    = {{(31-FRACTION_BITS){1'b0}}, 1'b1, op_r.fraction};
          sticky_next = 1'b0;
          if (e_s > 10'sd23) begin
            left_next = 1'b1;
            cnt_next  = 5'(e_s - 10'sd23);
          end else begin
            left_next = 1'b0;
            cnt_next  = 5'(10'sd23 - e_s);
          end
          if (e_s == 10'sd23) begin
            state_next = NEGATE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_r) begin
          mag_next = mag_r << 1;
        end else begin
          mag_next    = mag_r >> 1;
          sticky_next = sticky_r | mag_r[0];
        end
        cnt_next = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_next = NEGATE;
        end else begin
          state_next = SHIFT;
        end
      end
      NEGATE: begin
        if (op_r.sign) begin
          out_int_next = ~mag_r + 32'd1;
        end else begin
          out_int_next = mag_r;
        end
        out_flags_next = f2i_flags_t'({4'b0000, sticky_r});
        state_next     = DONE;
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and drops on handshake.
        if (out_valid_r && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else begin
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      op_r        <= float_t'(32'h0000_0000);
      mag_r       <= 32'h0000_0000;
      cnt_r       <= 5'd0;
      left_r      <= 1'b0;
      sticky_r    <= 1'b0;
      out_int_r   <= 32'h0000_0000;
      out_flags_r <= f2i_flags_t'(5'b00000);
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      op_r        <= op_next;
      mag_r       <= mag_next;
      cnt_r       <= cnt_next;
      left_r      <= left_next;
      sticky_r    <= sticky_next;
      out_int_r   <= out_int_next;
      out_flags_r <= out_flags_next;
      out_valid_r <= out_valid_next;
    end
  end

  // Output drive from registers / state decode.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = out_valid_r;
    out_int   = out_int_r;
    out_flags = out_flags_r;
  end

endmodule

// File: doc/float_to_int_seq.md
FLOAT_TO_INT_SEQ -- requirements
Module: float_to_int_seq

Interface
REQ-001 SHALL have parameter EXPONENT_BITS, default 8, exponent field width (from package floatingpoint).
REQ-002 SHALL have parameter FRACTION_BITS, default 23, fraction field width (from package floatingpoint).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_bits holds an operand.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_bits  input  32  IEEE single, laid out as {sign, exponent, fraction}.
REQ-008 SHALL have port out_valid  output  1  out_int and out_flags hold a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_int  output  32  signed two's-complement result.
REQ-011 SHALL have port out_flags  output  5  {nan, inf, overflow, zero, inexact}, with nan as the MSB.

Function
REQ-012 SHALL implement states IDLE, CLASSIFY, SHIFT, NEGATE, DONE.
REQ-013 SHALL assert in_ready only in IDLE, with no combinational path from out_ready.
REQ-014 SHALL capture in_bits and move to CLASSIFY on an edge where in_valid && in_ready.
REQ-015 CLASSIFY: SHALL form mant = {1'b1, fraction} (24 bits) and e = exponent - 127 (signed).
REQ-016 Special cases, all moving CLASSIFY -> DONE:
- exponent 0xFF with fraction != 0: out_int 0x7FFFFFFF, nan=1.
- exponent 0xFF with fraction == 0: out_int 0x7FFFFFFF (+) or 0x80000000 (-), inf=1.
- exponent 0 with fraction == 0: out_int 0, zero=1.
- exponent 0 with fraction != 0, or e < 0: out_int 0, zero=1, inexact=1.
- e > 31, or e == 31 and not (sign=1 and fraction=0): saturate as for inf, overflow=1.
REQ-017 Normal case (0 <= e <= 30, or exact -2^31): CLASSIFY SHALL load n = |e - 23| into a shift counter, then go to SHIFT if n > 0, else to NEGATE.
REQ-018 SHIFT: SHALL shift exactly one bit per cycle (left if e > 23, right if e < 23) and decrement n; it SHALL exit to NEGATE in the cycle n reaches 0.
REQ-019 Right shifts SHALL OR every discarded bit into a sticky inexact flag; rounding is truncation toward zero.
REQ-020 NEGATE: SHALL two's-complement the magnitude when sign=1, then go to DONE; -2^31 SHALL yield 0x80000000 with overflow=0.
REQ-021 Latency for accept edge k: out_valid SHALL rise after edge k+2 for special cases and after edge k+3+n for normal operands.
REQ-022 DONE: SHALL hold out_valid=1 with out_int and out_flags stable until out_valid && out_ready, then go to IDLE; the next operand is accepted no earlier than the following edge.
REQ-023 Outside DONE, out_valid SHALL be 0 and out_int/out_flags SHALL hold their last values.
REQ-024 in_bits changes while the block is not in IDLE SHALL have no effect.

Reset
REQ-025 While reset=1 at an edge, the block SHALL enter IDLE, clear out_valid, out_int, out_flags and the shift counter, and set in_ready=1 on the next cycle.
REQ-026 Reset asserted in any state, including mid-SHIFT or mid-DONE, SHALL discard the operation with no result emitted.

Structure
REQ-027 The state enum, the flags struct (nan, inf, overflow, zero, inexact) and the bias constant 127 SHALL be added to package floatingpoint, reusing its float type and field widths.
REQ-028 Classification SHALL be a combinational sub-module fp_classify (float in; is_nan, is_inf, is_zero, is_denorm out), consistent with the package's iszero/isnan/isinfinity functions.

Verification
REQ-029 The bench SHALL cover these scenarios (k = accept edge):
- 0x3F800000 (1.0) -> out_int 1, flags 0, n=23, out_valid after edge k+26.
- 0xC0200000 (-2.5) -> out_int 0xFFFFFFFE (-2), inexact=1; 0x4B800001 (2^24+2) -> 16777218, flags 0, n=1.
- 0x4F000000 -> 0x7FFFFFFF with overflow=1; 0xCF000000 -> 0x80000000 with flags 0.
- 0x7FC00000 -> 0x7FFFFFFF, nan=1, out_valid after edge k+2; 0x00000000 -> 0, zero=1; 0x00000001 -> 0, zero=1 and inexact=1.
- out_ready held low 5 cycles in DONE -> out_int/out_flags stable, in_ready=0; reset pulsed mid-SHIFT -> IDLE, out_valid=0, in_ready=1 next cycle.
